// File: rtl/mem_arbiter.sv
// Two-way arbiter sharing one main-memory port between the I-cache and the D-cache.
// D-side has priority; the streak counter lets a waiting I request win after STARVE_LIMIT D grants.
module mem_arbiter #(
    parameter int ADDR_W       = 28,
    parameter int DATA_W       = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              I_mem_read,
    input  logic              I_mem_write,
    input  logic [ADDR_W-1:0] I_mem_addr,
    input  logic [DATA_W-1:0] I_mem_wdata,
    output logic [DATA_W-1:0] I_mem_rdata,
    output logic              I_mem_ready,
    input  logic              D_mem_read,
    input  logic              D_mem_write,
    input  logic [ADDR_W-1:0] D_mem_addr,
    input  logic [DATA_W-1:0] D_mem_wdata,
    output logic [DATA_W-1:0] D_mem_rdata,
    output logic              D_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    typedef struct packed {
        logic              read;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t   state;
    logic [3:0] d_streak;
    mem_req_t req_i;
    mem_req_t req_d;
    mem_req_t req_sel;
    logic     want_i;
    logic     want_d;
    logic     pick_i;

    assign req_i  = {I_mem_read, I_mem_write, I_mem_addr, I_mem_wdata};
    assign req_d  = {D_mem_read, D_mem_write, D_mem_addr, D_mem_wdata};
    assign want_i = I_mem_read | I_mem_write;
    assign want_d = D_mem_read | D_mem_write;
    // I wins only when alone or when D has already taken LIMIT grants in a row past it
    assign pick_i = want_i && (!want_d || (d_streak >= LIMIT));

    always_comb begin
        req_sel = '0;
        case (state)
            GRANT_I: req_sel = req_i;
            GRANT_D: req_sel = req_d;
            default: req_sel = '0;
        endcase
    end

    assign mem_read    = req_sel.read;
    assign mem_write   = req_sel.write;
    assign mem_addr    = req_sel.addr;
    assign mem_wdata   = req_sel.wdata;
    assign I_mem_ready = (state == GRANT_I) && mem_ready;
    assign D_mem_ready = (state == GRANT_D) && mem_ready;
    assign I_mem_rdata = mem_rdata;
    assign D_mem_rdata = mem_rdata;

    // Every grant returns through IDLE, so a request dropped after its ready is never re-granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            d_streak <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_i) begin
                        state    <= GRANT_I;
                        d_streak <= 4'd0;
                    end else if (want_d) begin
                        state <= GRANT_D;
                        if (!want_i)
                            d_streak <= 4'd0;
                        else if (d_streak != 4'hF)
                            d_streak <= d_streak + 4'd1;
                    end
                end
                GRANT_I: if (mem_ready || !want_i) state <= IDLE;
                GRANT_D: if (mem_ready || !want_d) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected grants/readies,
// a negedge monitor pops and compares whenever the DUT strobes memory or pulses a ready.
module tb_mem_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         I_mem_read = 1'b0, I_mem_write = 1'b0;
    logic [27:0]  I_mem_addr = '0;
    logic [127:0] I_mem_wdata = '0;
    logic [127:0] I_mem_rdata;
    logic         I_mem_ready;
    logic         D_mem_read = 1'b0, D_mem_write = 1'b0;
    logic [27:0]  D_mem_addr = '0;
    logic [127:0] D_mem_wdata = '0;
    logic [127:0] D_mem_rdata;
    logic         D_mem_ready;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    logic         mem_ready = 1'b0;

    mem_arbiter #(.ADDR_W(28), .DATA_W(128), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .I_mem_read(I_mem_read), .I_mem_write(I_mem_write), .I_mem_addr(I_mem_addr),
        .I_mem_wdata(I_mem_wdata), .I_mem_rdata(I_mem_rdata), .I_mem_ready(I_mem_ready),
        .D_mem_read(D_mem_read), .D_mem_write(D_mem_write), .D_mem_addr(D_mem_addr),
        .D_mem_wdata(D_mem_wdata), .D_mem_rdata(D_mem_rdata), .D_mem_ready(D_mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [27:0]  a;
        logic [127:0] wd;
    } grant_t;

    typedef struct {
        bit           sd;
        logic [127:0] rdata;
    } ready_t;

    grant_t exp_g[$];
    ready_t exp_r[$];
    int     grant_cyc_q[$];
    int     total = 0, bad = 0;
    int     cyc = 0;
    int     done_i = 0, done_d = 0;
    int     last_ready_cyc = -1;
    int     mem_lat = 3;

    function automatic logic [127:0] pat(input logic [27:0] a);
        return {4{4'hA, a}};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input bit sd, input logic rd, input logic wr, input logic [27:0] a,
                        input logic [127:0] wd, input bit want_ready);
        grant_t g;
        ready_t r;
        g.rd = rd; g.wr = wr; g.a = a; g.wd = wd;
        exp_g.push_back(g);
        if (want_ready) begin
            r.sd = sd; r.rdata = pat(a);
            exp_r.push_back(r);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(I_mem_read && I_mem_write)) else $error("protocol violation: I read and write both high");
            assert (!(D_mem_read && D_mem_write)) else $error("protocol violation: D read and write both high");
        end
    end

    // Memory model: ready comes mem_lat cycles after the first strobe cycle
    int busy = 0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            busy = 0; mem_ready = 1'b0;
        end else if (mem_read || mem_write) begin
            busy++;
            if (busy == mem_lat + 1) begin
                mem_ready = 1'b1;
                mem_rdata = pat(mem_addr);
            end else mem_ready = 1'b0;
        end else begin
            busy = 0; mem_ready = 1'b0;
        end
    end

    // Monitor
    bit     prev_strobe = 1'b0;
    grant_t cur;
    always @(negedge clk) begin
        if (rst) prev_strobe = 1'b0;
        else begin
            if ((mem_read || mem_write) && !prev_strobe) begin
                grant_cyc_q.push_back(cyc);
                if (exp_g.size() == 0) chk("unexpected_grant", {100'd0, mem_addr}, 128'd0);
                else cur = exp_g.pop_front();
            end
            if (mem_read || mem_write) begin
                chk("mem_addr", {100'd0, mem_addr}, {100'd0, cur.a});
                chk("mem_rd_wr", {126'd0, mem_read, mem_write}, {126'd0, cur.rd, cur.wr});
                chk("mem_wdata", mem_wdata, cur.wd);
            end else if (mem_addr !== '0 || mem_wdata !== '0) begin
                chk("idle_mem_outputs", {100'd0, mem_addr} | mem_wdata, 128'd0);
            end
            if (I_mem_ready || D_mem_ready) begin
                last_ready_cyc = cyc;
                if (I_mem_ready && D_mem_ready) chk("both_ready", 128'd1, 128'd0);
                else if (exp_r.size() == 0) chk("unexpected_ready", {127'd0, D_mem_ready}, 128'd2);
                else begin
                    ready_t r;
                    r = exp_r.pop_front();
                    chk("ready_side", {127'd0, D_mem_ready}, {127'd0, r.sd});
                    chk("ready_rdata", D_mem_ready ? D_mem_rdata : I_mem_rdata, r.rdata);
                end
                if (I_mem_ready) done_i++;
                if (D_mem_ready) done_d++;
            end
            prev_strobe = mem_read || mem_write;
        end
    end

    // Requester: called at posedge+2; holds until its ready (hold==0) or for hold cycles
    task automatic do_req(input bit sd, input logic rd, input logic wr, input logic [27:0] a,
                          input logic [127:0] wd, input int hold);
        int start, n;
        if (sd) begin
            D_mem_read = rd; D_mem_write = wr; D_mem_addr = a; D_mem_wdata = wd; start = done_d;
        end else begin
            I_mem_read = rd; I_mem_write = wr; I_mem_addr = a; I_mem_wdata = wd; start = done_i;
        end
        if (hold == 0) begin
            n = 0;
            while (n < 200 && (sd ? done_d : done_i) == start) begin
                @(posedge clk);
                n++;
            end
            if (n >= 200) chk("req_timeout", {100'd0, a}, 128'd0);
        end else repeat (hold) @(posedge clk);
        #2;
        if (sd) begin
            D_mem_read = 0; D_mem_write = 0; D_mem_addr = '0; D_mem_wdata = '0;
        end else begin
            I_mem_read = 0; I_mem_write = 0; I_mem_addr = '0; I_mem_wdata = '0;
        end
    endtask

    task automatic gap();
        repeat (2) @(posedge clk);
        #2;
    endtask

    int c0;
    initial begin
        // reset state
        @(negedge clk);
        chk("rst_strobes", {126'd0, mem_read, mem_write}, 128'd0);
        chk("rst_addr", {100'd0, mem_addr}, 128'd0);
        chk("rst_wdata", mem_wdata, 128'd0);
        chk("rst_readies", {126'd0, I_mem_ready, D_mem_ready}, 128'd0);
        chk("rst_rdata_bcast", I_mem_rdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        @(posedge clk); #2;
        rst = 1'b0;
        gap();

        // 1: lone I read, ready 3 cycles after strobe
        mem_lat = 3;
        grant_cyc_q.delete();
        push(0, 1, 0, 28'h0000010, '0, 1);
        c0 = cyc;
        do_req(0, 1, 0, 28'h0000010, '0, 0);
        chk("t1_grant_cyc", grant_cyc_q.size() > 0 ? grant_cyc_q[0] : -1, c0 + 1);
        chk("t1_ready_cyc", last_ready_cyc, c0 + 4);
        gap();

        // 2: simultaneous I and D reads: D first, I after ready plus one bubble
        mem_lat = 2;
        grant_cyc_q.delete();
        push(1, 1, 0, 28'h0000020, '0, 1);
        push(0, 1, 0, 28'h0000030, '0, 1);
        c0 = cyc;
        fork
            do_req(1, 1, 0, 28'h0000020, '0, 0);
            do_req(0, 1, 0, 28'h0000030, '0, 0);
        join
        chk("t2_d_grant_cyc", grant_cyc_q.size() > 0 ? grant_cyc_q[0] : -1, c0 + 1);
        chk("t2_i_grant_cyc", grant_cyc_q.size() > 1 ? grant_cyc_q[1] : -1, c0 + 5);
        gap();

        // 3: D streams with I pending: 4 D, I, then streak restarts from 0
        mem_lat = 1;
        for (int k = 0; k < 4; k++) push(1, 1, 0, 28'h0000100 + 28'(k), '0, 1);
        push(0, 1, 0, 28'h0000040, '0, 1);
        for (int k = 4; k < 8; k++) push(1, 1, 0, 28'h0000100 + 28'(k), '0, 1);
        push(0, 1, 0, 28'h0000041, '0, 1);
        push(1, 1, 0, 28'h0000108, '0, 1);
        fork
            for (int k = 0; k < 9; k++) do_req(1, 1, 0, 28'h0000100 + 28'(k), '0, 0);
            begin
                do_req(0, 1, 0, 28'h0000040, '0, 0);
                do_req(0, 1, 0, 28'h0000041, '0, 0);
            end
        join
        gap();

        // 4: D writeback
        mem_lat = 2;
        push(1, 0, 1, 28'h0000070, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF, 1);
        do_req(1, 0, 1, 28'h0000070, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF, 0);
        gap();

        // 5: reset in the middle of a D grant
        mem_lat = 10;
        push(1, 1, 0, 28'h0000080, '0, 0);
        D_mem_read = 1; D_mem_addr = 28'h0000080;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_strobes", {126'd0, mem_read, mem_write}, 128'd0);
        chk("t5_addr", {100'd0, mem_addr}, 128'd0);
        chk("t5_readies", {126'd0, I_mem_ready, D_mem_ready}, 128'd0);
        D_mem_read = 0; D_mem_addr = '0;
        @(posedge clk); #2;
        rst = 1'b0;
        gap();
        mem_lat = 2;
        push(0, 1, 0, 28'h0000090, '0, 1);
        do_req(0, 1, 0, 28'h0000090, '0, 0);
        gap();

        // 6: granted I drops its request before mem_ready
        mem_lat = 10;
        push(0, 1, 0, 28'h00000A0, '0, 0);
        do_req(0, 1, 0, 28'h00000A0, '0, 3);
        @(posedge clk); #1;
        chk("t6_strobes", {126'd0, mem_read, mem_write}, 128'd0);
        chk("t6_addr", {100'd0, mem_addr}, 128'd0);
        #1;
        mem_lat = 1;
        push(1, 1, 0, 28'h00000B0, '0, 1);
        do_req(1, 1, 0, 28'h00000B0, '0, 0);
        gap();

        chk("grants_left", exp_g.size(), 0);
        chk("readies_left", exp_r.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end
endmodule
